reg_display_scan: RTL and testbench

- Board-level companion to mccomp. Drives mccomp's reg_sel and consumes its reg_data.
- Two debounced push-buttons step reg_sel through registers 0..31.
- The selected 32-bit register is shown as 8 hex digits on a multiplexed, active-low seven-segment display.
- Sits beside mccomp in the FPGA top level, replacing the testbench's direct reg_sel drive.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 70 +++++++
 rtl/reg_display_scan.sv | 86 ++++++++
 tb/tb_reg_display_scan.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the register display scanner:
// hex-to-segment table, debouncer states and digit count.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    // Entry n is the {g,f,e,d,c,b,a} active-high pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer and hysteretic debouncer producing one pulse per press.
module btn_debounce
    import seg7_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             synced;
    db_state_t        state_reg;
    logic [CNT_W-1:0] count_reg;

    assign synced = sync_reg[1];

    // Decoded from registered state so reg_sel can follow on the very next edge.
    assign press_pulse = (state_reg == ARM) && synced && (count_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_reg  <= 2'b00;
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], btn_raw};
            case (state_reg)
                IDLE: begin
                    if (synced) begin
                        state_reg <= ARM;
                        count_reg <= '0;
                    end
                end
                ARM: begin
                    if (!synced) begin
                        state_reg <= IDLE;
                    end else if (count_reg == CNT_LAST) begin
                        state_reg <= HELD;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                HELD: begin
                    if (!synced) begin
                        state_reg <= RELEASE;
                        count_reg <= '0;
                    end
                end
                RELEASE: begin
                    // A bounce back high keeps the button held; no second pulse.
                    if (synced) begin
                        state_reg <= HELD;
                    end else if (count_reg == CNT_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/reg_display_scan.sv
// Button-driven register selector for mccomp with an 8-digit multiplexed
// active-low seven-segment hex display of the selected register.
module reg_display_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic [31:0] reg_data,
    output logic [4:0]  reg_sel,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [1:0]       btn_raw;
    logic [1:0]       pulse;
    logic [DIV_W-1:0] div_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [31:0]      snap_reg;
    logic [4:0]       sel_reg;
    logic [7:0]       an_reg;
    logic [7:0]       seg_reg;
    logic             frame_start;
    logic [3:0]       nibble;

    assign btn_raw = {btn_prev, btn_next};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk        (clk),
                .rstn       (rstn),
                .btn_raw    (btn_raw[gi]),
                .press_pulse(pulse[gi])
            );
        end
    endgenerate

    assign frame_start = (div_reg == '0) && (idx_reg == '0);
    // Digit 0 at frame start shows live data since the snapshot is loading this edge.
    assign nibble = frame_start ? reg_data[3:0] : snap_reg[{idx_reg, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_reg  <= '0;
            idx_reg  <= '0;
            snap_reg <= '0;
            sel_reg  <= '0;
            an_reg   <= 8'hFF;
            seg_reg  <= 8'hFF;
        end else begin
            if (div_reg == DIV_LAST) begin
                div_reg <= '0;
                idx_reg <= idx_reg + 1'b1;
            end else begin
                div_reg <= div_reg + 1'b1;
            end
            if (frame_start) begin
                snap_reg <= reg_data;
            end
            an_reg  <= ~(8'd1 << idx_reg);
            seg_reg <= {1'b1, ~HEX_TABLE[nibble]};
            case (pulse)
                2'b01:   sel_reg <= sel_reg + 5'd1;
                2'b10:   sel_reg <= sel_reg - 5'd1;
                default: sel_reg <= sel_reg;
            endcase
        end
    end

    assign reg_sel = sel_reg;
    assign an      = an_reg;
    assign seg     = seg_reg;

endmodule

// File: tb/tb_reg_display_scan.sv
// Self-checking bench for reg_display_scan: directed scenarios plus random
// button/data/reset traffic against a run-length behavioural model.
module tb_reg_display_scan;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 8;
    localparam int FRAME    = SCAN_DIV * 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        btn_next;
    logic        btn_prev;
    logic [31:0] reg_data;
    logic [4:0]  reg_sel;
    logic [7:0]  an;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_cnt;
    logic [31:0] m_snap;
    logic [4:0]  m_sel;
    logic [7:0]  exp_an;
    logic [7:0]  exp_seg;
    logic [1:0]  m_dly [2];
    logic        m_lvl [2];
    int          m_run [2];

    reg_display_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .reg_data(reg_data),
        .reg_sel (reg_sel),
        .an      (an),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  4'hF: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, compare all outputs 1 time unit later.
    task automatic step();
        logic [1:0] raw;
        logic [1:0] pulse;
        logic       synced;
        logic [3:0] nib;
        int         c;
        int         idx;
        @(posedge clk);
        raw = {btn_prev, btn_next};
        if (!rstn) begin
            m_cnt = 0; m_snap = '0; m_sel = '0;
            exp_an = 8'hFF; exp_seg = 8'hFF;
            for (int b = 0; b < 2; b++) begin
                m_dly[b] = 2'b00; m_lvl[b] = 1'b0; m_run[b] = 0;
            end
        end else begin
            c   = m_cnt;
            idx = (c / SCAN_DIV) % 8;
            if (c % FRAME == 0) begin
                m_snap = reg_data;
                nib    = reg_data[3:0];
            end else begin
                nib = m_snap[4*idx +: 4];
            end
            exp_an  = ~(8'd1 << idx);
            exp_seg = {1'b1, ~hex7(nib)};
            m_cnt++;
            // A level is accepted after DB+1 consecutive synchronized samples disagreeing with it.
            for (int b = 0; b < 2; b++) begin
                synced   = m_dly[b][1];
                m_dly[b] = {m_dly[b][0], raw[b]};
                pulse[b] = 1'b0;
                if (synced != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB + 1) begin
                        m_lvl[b] = synced;
                        m_run[b] = 0;
                        pulse[b] = synced;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            if (pulse == 2'b01)      m_sel = m_sel + 5'd1;
            else if (pulse == 2'b10) m_sel = m_sel - 5'd1;
        end
        #1;
        chk("an", {24'd0, an}, {24'd0, exp_an});
        chk("seg", {24'd0, seg}, {24'd0, exp_seg});
        chk("reg_sel", {27'd0, reg_sel}, {27'd0, m_sel});
    endtask

    task automatic press(input logic nxt, input logic prv);
        btn_next = nxt;
        btn_prev = prv;
        repeat (20) step();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (20) step();
    endtask

    logic [7:0] an_tab  [8];
    logic [7:0] seg_tab [8];
    logic [4:0] last_sel;
    int         changes;
    int         at_step;
    int         hold;

    initial begin
        an_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        seg_tab = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
        rstn     = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        reg_data = 32'h0123ABCD;

        // Reset
        repeat (3) step();
        chk("rst_sel", {27'd0, reg_sel}, 32'd0);
        chk("rst_an", {24'd0, an}, 32'hFF);
        chk("rst_seg", {24'd0, seg}, 32'hFF);

        // Scan sequence from reset release
        rstn = 1'b1;
        for (int n = 0; n < 32; n++) begin
            step();
            chk("scan_an", {24'd0, an}, {24'd0, an_tab[n/4]});
            chk("scan_seg", {24'd0, seg}, {24'd0, seg_tab[n/4]});
        end

        // Single press: exactly one increment, 11 cycles after the rise
        changes  = 0;
        at_step  = -1;
        last_sel = reg_sel;
        for (int i = 0; i < 40; i++) begin
            btn_next = (i < 20);
            step();
            if (reg_sel !== last_sel) begin
                changes++;
                if (at_step < 0) at_step = i + 1;
                last_sel = reg_sel;
            end
        end
        chk("db_latency", at_step, 32'd11);
        chk("db_once", changes, 32'd1);
        chk("db_sel", {27'd0, reg_sel}, 32'd1);

        // Bouncing input never accepted
        for (int i = 0; i < 30; i++) begin
            btn_next = ((i / 3) % 2 == 0);
            step();
        end
        btn_next = 1'b0;
        repeat (20) step();
        chk("bounce_sel", {27'd0, reg_sel}, 32'd1);

        // Wrap in both directions
        press(1'b0, 1'b1);
        chk("prev_sel", {27'd0, reg_sel}, 32'd0);
        press(1'b0, 1'b1);
        chk("wrap_prev", {27'd0, reg_sel}, 32'd31);
        press(1'b1, 1'b0);
        chk("wrap_next", {27'd0, reg_sel}, 32'd0);

        // Simultaneous presses cancel
        press(1'b1, 1'b1);
        chk("both_sel", {27'd0, reg_sel}, 32'd0);

        // Snapshot: change data while digit 3 is about to show
        for (int k = 0; k < FRAME + 2 && (m_cnt % FRAME) != 0; k++) step();
        repeat (3 * SCAN_DIV) step();
        reg_data = 32'hFFFFFFFF;
        repeat (FRAME - 3 * SCAN_DIV) step();
        chk("snap_old", {24'd0, seg}, 32'hC0);
        for (int n = 0; n < FRAME; n++) begin
            step();
            chk("snap_new", {24'd0, seg}, 32'h8E);
        end

        // Reset mid-frame
        repeat (5) press(1'b1, 1'b0);
        chk("sel5", {27'd0, reg_sel}, 32'd5);
        repeat (3) step();
        rstn = 1'b0;
        step();
        chk("mid_rst_an", {24'd0, an}, 32'hFF);
        chk("mid_rst_seg", {24'd0, seg}, 32'hFF);
        chk("mid_rst_sel", {27'd0, reg_sel}, 32'd0);
        rstn = 1'b1;
        step();
        chk("post_rst_an", {24'd0, an}, 32'hFE);

        // Random buttons, data and occasional resets against the model
        for (int it = 0; it < 60; it++) begin
            hold     = $urandom_range(1, 25);
            btn_next = $urandom_range(0, 1);
            btn_prev = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) reg_data = $urandom;
            rstn = ($urandom_range(0, 19) != 0);
            step();
            rstn = 1'b1;
            repeat (hold) step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
